mem_responder: RTL and testbench

- Memory-side responder for the LC-3b datapath's memory interface.
- The datapath acts as initiator: it presents ADDR from MAR, shares the 16-bit tri-state Data bus, and requests reads or writes. This block answers those requests.
- It contains an internal word-addressed storage array, inserts a programmable number of wait states, and signals completion with a one-cycle mem_resp.
- It sits between the datapath's ADDR/Data pins and the rest of the system, and stands in for SRAM in simulation and on the board.

---
 rtl/mem_responder.sv | 163 ++++++++++++++++
 tb/tb_mem_responder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: word-addressed memory responder for the LC-3b memory interface.
// Answers mem_read/mem_write requests after WAIT_CYCLES wait states with a
// single-cycle mem_resp pulse. mem_err accompanies the pulse for out-of-range
// word indices and for simultaneous read+write requests.
// Optional build macro: MEM_BYTE_WRITE_EN adds the mem_byte_en port and
// per-lane write enables. When it is undefined, all writes are full 16-bit writes.
//
// state | meaning
// IDLE  | no transaction; waiting for mem_read or mem_write
// WAIT  | request latched; counting down wait states
// RESP  | one-cycle response; mem_resp high, read data on Data
// HOLD  | response given; waiting for both requests to drop

module mem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [15:0] ADDR,
    inout  wire  [15:0] Data,
`ifdef MEM_BYTE_WRITE_EN
    input  logic [1:0]  mem_byte_en,
`endif
    output logic        mem_resp,
    output logic        mem_err
);

    localparam int          IDX_W     = $clog2(DEPTH);
    localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic [15:0] DEPTH_W   = 16'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP, HOLD} state_t;

    state_t      state;
    logic [3:0]  wait_cnt;
    logic [14:0] word_idx;
    logic        op_rd;
    logic        op_wr;
    logic [15:0] rd_q;
    logic [15:0] mem [DEPTH];

    logic        req;
    logic [14:0] cur_idx;
    logic        cur_rd;
    logic        cur_wr;
    logic        in_range;
    logic        cur_err;
    logic        enter_resp;
    logic        do_write;
    logic        drive_en;
    logic [1:0]  lane_en;
    logic        unused_addr_lsb;

    assign req             = mem_read | mem_write;
    assign unused_addr_lsb = ADDR[0];

`ifdef MEM_BYTE_WRITE_EN
    assign lane_en = mem_byte_en;
`else
    assign lane_en = 2'b11;
`endif

    // Effective transaction view: live inputs while detecting, latched values afterwards.
    always_comb begin
        cur_idx    = word_idx;
        cur_rd     = op_rd;
        cur_wr     = op_wr;
        if (state == IDLE) begin
            cur_idx = ADDR[15:1];
            cur_rd  = mem_read;
            cur_wr  = mem_write;
        end
        in_range   = {1'b0, cur_idx} < DEPTH_W;
        cur_err    = !in_range || (cur_rd && cur_wr);
        enter_resp = req && (((state == IDLE) && (WAIT_CYCLES == 0)) ||
                             ((state == WAIT) && (wait_cnt == 4'd0)));
        do_write   = enter_resp && cur_wr && !cur_rd && in_range;
    end

    // Only a clean read of the latched operation drives the shared bus, and only in RESP.
    assign drive_en = (state == RESP) && mem_read && op_rd && !op_wr;
    assign Data     = drive_en ? rd_q : 16'hzzzz;

    // Transaction sequencing and registered response outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
            word_idx <= 15'd0;
            op_rd    <= 1'b0;
            op_wr    <= 1'b0;
            mem_resp <= 1'b0;
            mem_err  <= 1'b0;
        end else begin
            mem_resp <= 1'b0;
            mem_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        word_idx <= ADDR[15:1];
                        op_rd    <= mem_read;
                        op_wr    <= mem_write;
                        wait_cnt <= WAIT_LOAD;
                        if (WAIT_CYCLES == 0) begin
                            state    <= RESP;
                            mem_resp <= 1'b1;
                            mem_err  <= cur_err;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!req) begin
                        state <= IDLE;
                    end else if (wait_cnt == 4'd0) begin
                        state    <= RESP;
                        mem_resp <= 1'b1;
                        mem_err  <= cur_err;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESP: begin
                    state <= HOLD;
                end
                HOLD: begin
                    if (!req) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Array write on the edge entering RESP; contents survive reset.
    always_ff @(posedge Clk) begin
        if (!Reset && do_write) begin
            if (lane_en[1]) begin
                mem[cur_idx[IDX_W-1:0]][15:8] <= Data[15:8];
            end
            if (lane_en[0]) begin
                mem[cur_idx[IDX_W-1:0]][7:0] <= Data[7:0];
            end
        end
    end

    // Read data captured on the edge entering RESP; out-of-range reads return zero.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rd_q <= 16'h0000;
        end else if (enter_resp) begin
            rd_q <= in_range ? mem[cur_idx[IDX_W-1:0]] : 16'h0000;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: directed transactions against a schedule-based
// model of expected responses, checked on every cycle, plus literal checks.

module tb_mem_responder;

    localparam int DEPTH       = 256;
    localparam int WAIT_CYCLES = 2;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic        rd     = 1'b0;
    logic        wr     = 1'b0;
    logic [15:0] addr   = 16'h0000;
    logic [1:0]  be     = 2'b11;
    logic        tb_drv = 1'b0;
    logic [15:0] tb_val = 16'h0000;
    logic        mem_resp;
    logic        mem_err;
    wire  [15:0] data_bus;

    // Undriven bus reads as all ones, so a released bus is distinguishable from driven data.
    assign data_bus = tb_drv ? tb_val : 16'hzzzz;
    pullup (data_bus);

    mem_responder #(
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .Clk         (clk),
        .Reset       (rst),
        .mem_read    (rd),
        .mem_write   (wr),
        .ADDR        (addr),
        .Data        (data_bus),
`ifdef MEM_BYTE_WRITE_EN
        .mem_byte_en (be),
`endif
        .mem_resp    (mem_resp),
        .mem_err     (mem_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    bit          exp_resp [int];
    bit          exp_err  [int];
    logic [15:0] exp_data [int];
    logic [15:0] mdl      [int];

    int          lat;
    logic [15:0] got;
    logic        got_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    // Per-cycle comparison against the response schedule.
    initial begin
        forever begin
            @(negedge clk);
            if (cyc >= 1) begin
                chk("mem_resp", {31'd0, mem_resp}, {31'd0, exp_resp.exists(cyc)});
                chk("mem_err", {31'd0, mem_err},
                    {31'd0, exp_err.exists(cyc) ? exp_err[cyc] : 1'b0});
                if (!tb_drv) begin
                    chk("data_bus", {16'd0, data_bus},
                        {16'd0, exp_data.exists(cyc) ? exp_data[cyc] : 16'hFFFF});
                end
            end
        end
    end

    // mode 0: complete transaction; 1: drop request after one wait cycle; 2: reset mid-wait
    task automatic txn(input bit r, input bit w, input logic [15:0] a, input logic [15:0] wd,
                       input logic [1:0] b, input int hold, input int mode,
                       output int l, output logic [15:0] g, output logic ge);
        int c;
        int rc;
        int idx;
        logic [15:0] old;
        l  = -1;
        g  = 16'h0000;
        ge = 1'b0;
        @(negedge clk);
        #1;
        c      = cyc;
        addr   = a;
        rd     = r;
        wr     = w;
        be     = b;
        tb_drv = w && !r;
        tb_val = wd;
        idx    = int'(a[15:1]);
        rc     = c + 1 + WAIT_CYCLES;
        if (mode == 0) begin
            exp_resp[rc] = 1'b1;
            exp_err[rc]  = (r && w) || (idx >= DEPTH);
            if (r && !w) begin
                exp_data[rc] = (idx < DEPTH) ? mdl[idx] : 16'h0000;
            end
            if (w && !r && idx < DEPTH) begin
                old = mdl.exists(idx) ? mdl[idx] : 16'h0000;
`ifdef MEM_BYTE_WRITE_EN
                mdl[idx] = {b[1] ? wd[15:8] : old[15:8], b[0] ? wd[7:0] : old[7:0]};
`else
                mdl[idx] = wd;
`endif
            end
            for (int k = c + 1; k <= rc + hold; k++) begin
                @(negedge clk);
                if (mem_resp && l < 0) begin
                    l  = cyc - c;
                    g  = data_bus;
                    ge = mem_err;
                end
                #1;
            end
        end else begin
            @(negedge clk);
            #1;
            if (mode == 2) rst = 1'b1;
            rd     = 1'b0;
            wr     = 1'b0;
            tb_drv = 1'b0;
            @(negedge clk);
            if (mem_resp && l < 0) l = cyc - c;
            #1;
            rst = 1'b0;
        end
        rd     = 1'b0;
        wr     = 1'b0;
        tb_drv = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (mem_resp && l < 0) l = cyc - c;
            #1;
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: bench did not finish, actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;

        txn(1'b0, 1'b1, 16'h0010, 16'hBEEF, 2'b11, 0, 0, lat, got, got_e);
        chk("wr_0010_latency", lat, 3);
        chk("wr_0010_err", {31'd0, got_e}, 0);
        txn(1'b1, 1'b0, 16'h0010, 16'h0000, 2'b11, 0, 0, lat, got, got_e);
        chk("rd_0010_data", {16'd0, got}, 32'h0000BEEF);
        chk("rd_0010_latency", lat, 3);
        txn(1'b1, 1'b0, 16'h0011, 16'h0000, 2'b11, 5, 0, lat, got, got_e);
        chk("rd_0011_data", {16'd0, got}, 32'h0000BEEF);
        txn(1'b1, 1'b0, 16'h0011, 16'h0000, 2'b11, 0, 0, lat, got, got_e);
        chk("rd_0011_rearm_latency", lat, 3);

        txn(1'b0, 1'b1, 16'h0000, 16'h1111, 2'b11, 0, 0, lat, got, got_e);
        txn(1'b1, 1'b0, 16'h0200, 16'h0000, 2'b11, 0, 0, lat, got, got_e);
        chk("rd_oor_err", {31'd0, got_e}, 1);
        chk("rd_oor_data", {16'd0, got}, 32'h00000000);
        txn(1'b1, 1'b0, 16'h0000, 16'h0000, 2'b11, 0, 0, lat, got, got_e);
        chk("rd_0000_data", {16'd0, got}, 32'h00001111);

        txn(1'b1, 1'b1, 16'h0010, 16'h0000, 2'b11, 1, 0, lat, got, got_e);
        chk("both_err", {31'd0, got_e}, 1);
        txn(1'b1, 1'b0, 16'h0010, 16'h0000, 2'b11, 0, 0, lat, got, got_e);
        chk("rd_0010_after_both", {16'd0, got}, 32'h0000BEEF);

        txn(1'b0, 1'b1, 16'h0020, 16'h4321, 2'b11, 0, 0, lat, got, got_e);
        txn(1'b0, 1'b1, 16'h0020, 16'h1234, 2'b11, 0, 1, lat, got, got_e);
        chk("abort_no_resp", lat, 32'hFFFFFFFF);
        txn(1'b1, 1'b0, 16'h0020, 16'h0000, 2'b11, 0, 0, lat, got, got_e);
        chk("rd_0020_after_abort", {16'd0, got}, 32'h00004321);
        txn(1'b0, 1'b1, 16'h0020, 16'h1234, 2'b11, 0, 2, lat, got, got_e);
        chk("reset_no_resp", lat, 32'hFFFFFFFF);
        txn(1'b1, 1'b0, 16'h0020, 16'h0000, 2'b11, 0, 0, lat, got, got_e);
        chk("rd_0020_after_reset", {16'd0, got}, 32'h00004321);

        txn(1'b0, 1'b1, 16'h01FE, 16'hA5A5, 2'b11, 0, 0, lat, got, got_e);
        chk("wr_last_err", {31'd0, got_e}, 0);
        txn(1'b1, 1'b0, 16'h01FE, 16'h0000, 2'b11, 0, 0, lat, got, got_e);
        chk("rd_last_data", {16'd0, got}, 32'h0000A5A5);
        txn(1'b0, 1'b1, 16'h0200, 16'h6666, 2'b11, 0, 0, lat, got, got_e);
        chk("wr_oor_err", {31'd0, got_e}, 1);
        txn(1'b1, 1'b0, 16'h0000, 16'h0000, 2'b11, 0, 0, lat, got, got_e);
        chk("rd_0000_after_oor_wr", {16'd0, got}, 32'h00001111);

`ifdef MEM_BYTE_WRITE_EN
        txn(1'b0, 1'b1, 16'h0040, 16'h5555, 2'b11, 0, 0, lat, got, got_e);
        txn(1'b0, 1'b1, 16'h0040, 16'hAAAA, 2'b01, 0, 0, lat, got, got_e);
        txn(1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, 0, 0, lat, got, got_e);
        chk("rd_byte_lo", {16'd0, got}, 32'h000055AA);
        txn(1'b0, 1'b1, 16'h0040, 16'h0000, 2'b00, 0, 0, lat, got, got_e);
        chk("wr_be00_latency", lat, 3);
        txn(1'b1, 1'b0, 16'h0040, 16'h0000, 2'b11, 0, 0, lat, got, got_e);
        chk("rd_be00_data", {16'd0, got}, 32'h000055AA);
`endif

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
